// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with handshake, radix-2 multiply/divide and status flags.
// Define SEQ_ALU_MULDIV_EN to build the iterative MUL/DIV/MOD datapath.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_e,
    output logic             flag_l
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                           OP_MOD = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_SAL = 4'd7,
                           OP_SAR = 4'd8, OP_ROR = 4'd9, OP_ROL = 4'd10, OP_AND = 4'd11,
                           OP_OR = 4'd12, OP_XOR = 4'd13, OP_NOT = 4'd14, OP_PASS = 4'd15;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    logic [WIDTH:0]   sum, dif, shl_x;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] ny;
    logic             nc, nv, go_busy;

    assign in_ready = (state == IDLE);

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        dif   = {1'b0, a} - {1'b0, b};
        sh    = b[SHW-1:0];
        shl_x = {1'b0, a} << sh;
        ny    = '0;
        nc    = 1'b0;
        nv    = 1'b0;
        case (op)
            OP_ADD: begin
                ny = sum[WIDTH-1:0];
                nc = sum[WIDTH];
                nv = (a[WIDTH-1] == b[WIDTH-1]) && (ny[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                ny = dif[WIDTH-1:0];
                nc = dif[WIDTH];
                nv = (a[WIDTH-1] != b[WIDTH-1]) && (ny[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL, OP_SAL: begin
                ny = shl_x[WIDTH-1:0];
                nc = shl_x[WIDTH];
            end
            OP_SHR:  ny = a >> sh;
            OP_SAR:  ny = $signed(a) >>> sh;
            OP_ROR:  ny = (a >> sh) | (a << (WIDTH - sh));
            OP_ROL:  ny = (a << sh) | (a >> (WIDTH - sh));
            OP_AND:  ny = a & b;
            OP_OR:   ny = a | b;
            OP_XOR:  ny = a ^ b;
            OP_NOT:  ny = ~a;
            OP_PASS: ny = a;
            // MUL/DIV/MOD without the iterative datapath report a zero result with overflow
            default: nv = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   ra, rb, fy, fhi;
    logic [3:0]         rop;
    logic [2*WIDTH-1:0] p, pn;
    logic [WIDTH:0]     s, t, d;
    logic               fv;

    assign go_busy = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);

    // p holds {acc, multiplier} for MUL and {remainder, quotient} for DIV/MOD
    always_comb begin
        s   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, ra} : '0);
        t   = p[2*WIDTH-1:WIDTH-1];
        d   = t - {1'b0, rb};
        pn  = (rop == OP_MUL) ? {s, p[WIDTH-1:1]} :
              d[WIDTH] ? {t[WIDTH-1:0], p[WIDTH-2:0], 1'b0} : {d[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        fy  = pn[WIDTH-1:0];
        fhi = pn[2*WIDTH-1:WIDTH];
        fv  = (rop == OP_MUL) && (|fhi);
        if (rop != OP_MUL && rb == '0) begin
            fy  = (rop == OP_DIV) ? '1 : ra;
            fhi = (rop == OP_DIV) ? ra : '1;
            fv  = 1'b1;
        end else if (rop == OP_MOD) begin
            fy  = pn[2*WIDTH-1:WIDTH];
            fhi = pn[WIDTH-1:0];
        end
    end
`else
    assign go_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            y         <= '0;
            y_hi      <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_e    <= 1'b0;
            flag_l    <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            cnt       <= '0;
            p         <= '0;
            ra        <= '0;
            rb        <= '0;
            rop       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
`ifdef SEQ_ALU_MULDIV_EN
                    ra  <= a;
                    rb  <= b;
                    rop <= op;
                    cnt <= '0;
                    p   <= {{WIDTH{1'b0}}, (op == OP_MUL) ? b : a};
`endif
                    if (go_busy) begin
                        state <= BUSY;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        y         <= ny;
                        y_hi      <= '0;
                        flag_n    <= ny[WIDTH-1];
                        flag_z    <= (ny == '0);
                        flag_c    <= nc;
                        flag_v    <= nv;
                        flag_e    <= (a == b);
                        flag_l    <= ($signed(a) < $signed(b));
                    end
                end
`ifdef SEQ_ALU_MULDIV_EN
                BUSY: begin
                    p   <= pn;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        y         <= fy;
                        y_hi      <= fhi;
                        flag_n    <= fy[WIDTH-1];
                        flag_z    <= (fy == '0);
                        flag_c    <= 1'b0;
                        flag_v    <= fv;
                        flag_e    <= (ra == rb);
                        flag_l    <= ($signed(ra) < $signed(rb));
                    end
                end
`endif
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (WIDTH=16), both SEQ_ALU_MULDIV_EN builds.
module tb_seq_alu;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [15:0] a = '0, b = '0, y, y_hi;
    logic [3:0]  op = '0;
    logic        flag_n, flag_z, flag_c, flag_v, flag_e, flag_l;
    logic [5:0]  fl;
    int          checks = 0, failures = 0, lat;
    logic        seen;

`ifdef SEQ_ALU_MULDIV_EN
    localparam int MDL = 17;
`else
    localparam int MDL = 1;
`endif

    assign fl = {flag_n, flag_z, flag_c, flag_v, flag_e, flag_l};

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_hi(y_hi), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
        .flag_v(flag_v), .flag_e(flag_e), .flag_l(flag_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble the inputs after accept, and measure latency to out_valid.
    task automatic run(input string tag, input logic [3:0] o, input logic [15:0] x, input logic [15:0] z,
                       input int exp_lat);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = z;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; a = ~x; b = ~z; op = ~o;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic result(input string tag, input logic [15:0] ey, input logic [15:0] ehi, input logic [5:0] ef);
        check({tag, "_y"}, 64'(y), 64'(ey));
        check({tag, "_y_hi"}, 64'(y_hi), 64'(ehi));
        check({tag, "_flags"}, 64'(fl), 64'(ef));
    endtask

    task automatic take(input string tag);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_back_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2;
        check("reset_async_y", 64'({y, y_hi}), 64'd0);
        check("reset_flags", 64'(fl), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // flags order: n z c v e l
        run("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 1);   result("add_ovf", 16'h8000, 16'h0, 6'b100100); take("add_ovf");
        run("sub_brw", 4'd1, 16'h0003, 16'h0005, 1);   result("sub_brw", 16'hFFFE, 16'h0, 6'b101001); take("sub_brw");
        run("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 1);  result("add_wrap", 16'h0000, 16'h0, 6'b011001); take("add_wrap");
        run("shl1", 4'd5, 16'h8001, 16'h0001, 1);      result("shl1", 16'h0002, 16'h0, 6'b001001); take("shl1");
        run("sal0", 4'd7, 16'h8001, 16'h0010, 1);      result("sal0", 16'h8001, 16'h0, 6'b100001); take("sal0");
        run("sar3", 4'd8, 16'h8000, 16'h0003, 1);      result("sar3", 16'hF000, 16'h0, 6'b100001); take("sar3");
        run("shr3", 4'd6, 16'h8000, 16'h0003, 1);      check("shr3_y", 64'(y), 64'h1000); take("shr3");
        run("ror1", 4'd9, 16'h0001, 16'h0001, 1);      check("ror1_y", 64'(y), 64'h8000); take("ror1");
        run("and", 4'd11, 16'hF0F0, 16'hFF00, 1);      check("and_y", 64'(y), 64'hF000); take("and");
        run("or", 4'd12, 16'hF0F0, 16'hFF00, 1);       check("or_y", 64'(y), 64'hFFF0); take("or");
        run("xor", 4'd13, 16'hF0F0, 16'hFF00, 1);      check("xor_y", 64'(y), 64'h0FF0); take("xor");
        run("not", 4'd14, 16'hF0F0, 16'hFF00, 1);      check("not_y", 64'(y), 64'h0F0F); take("not");
        run("pass_eq", 4'd15, 16'h1234, 16'h1234, 1);  result("pass_eq", 16'h1234, 16'h0, 6'b000010); take("pass_eq");

        run("rol_hold", 4'd10, 16'h8001, 16'h0004, 1);
        for (int i = 0; i < 5; i++) begin
            check("rol_hold_y", 64'(y), 64'h0018);
            check("rol_hold_valid", 64'(out_valid), 64'd1);
            check("rol_hold_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        take("rol_hold");

`ifdef SEQ_ALU_MULDIV_EN
        run("mul", 4'd2, 16'h1234, 16'h0100, MDL);     result("mul", 16'h3400, 16'h0012, 6'b000100); take("mul");
        run("div0", 4'd3, 16'd100, 16'd0, MDL);        result("div0", 16'hFFFF, 16'd100, 6'b100100); take("div0");
        run("div7", 4'd3, 16'd100, 16'd7, MDL);        result("div7", 16'd14, 16'd2, 6'b000000); take("div7");
        run("mod7", 4'd4, 16'd100, 16'd7, MDL);        result("mod7", 16'd2, 16'd14, 6'b000000); take("mod7");
        run("mod0", 4'd4, 16'd100, 16'd0, MDL);        result("mod0", 16'd100, 16'hFFFF, 6'b000100); take("mod0");
`else
        run("mul", 4'd2, 16'h1234, 16'h0100, MDL);     result("mul", 16'h0, 16'h0, 6'b010100); take("mul");
        run("div0", 4'd3, 16'd100, 16'd0, MDL);        result("div0", 16'h0, 16'h0, 6'b010100); take("div0");
        run("mod7", 4'd4, 16'd100, 16'd7, MDL);        result("mod7", 16'h0, 16'h0, 6'b010100); take("mod7");
`endif

        @(negedge clk);
        in_valid = 1'b1; op = 4'd2; a = 16'h1234; b = 16'h0100;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("abort_valid_low", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        run("add_after", 4'd0, 16'd2, 16'd3, 1);       result("add_after", 16'd5, 16'h0, 6'b000001); take("add_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end
endmodule
